icache_refill_ctrl: RTL and testbench

Sequencing controller for the instruction cache. It accepts CPU fetch requests, drives the cache lookup, and on a miss fetches the full line from memory as a burst. It writes each beat into the cache fill port, then returns the requested word to the CPU. It sits between the fetch stage, the icache array and the memory-side read port.

---
 rtl/icache_refill_ctrl.sv | 145 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// Module      : icache_refill_ctrl
// Description : I-cache fetch sequencer: lookup, line refill burst, word return.
//               Optional macro ICACHE_EARLY_RESTART_EN returns the critical word
//               as soon as it arrives instead of after the whole line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_data,
  output logic              lk_valid,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              lk_hit,
  input  logic [31:0]       lk_data,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [31:0]       fill_data,
  output logic              fill_last,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF   = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] CHECK    = 3'd2;
  localparam logic [2:0] MISS_REQ = 3'd3;
  localparam logic [2:0] REFILL   = 3'd4;
  localparam logic [2:0] RESP     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic [ADDR_W-1:0] line_base;
  logic [IDX_W-1:0]  word_idx;
  logic              beat_fire;
  logic              beat_last;
  logic              beat_crit;

  assign line_base = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign word_idx  = addr_q[OFF-1:2];
  assign beat_fire = (state_q == REFILL) && mem_rsp_valid;
  assign beat_last = beat_fire && (beat_q == LAST_BEAT);
  assign beat_crit = beat_fire && (beat_q == word_idx);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cpu_req_valid) state_d = LOOKUP;
      LOOKUP:   state_d = CHECK;
      CHECK:    state_d = lk_hit ? RESP : MISS_REQ;
      MISS_REQ: if (mem_req_ready) state_d = REFILL;
      REFILL: begin
        if (beat_last) begin
`ifdef ICACHE_EARLY_RESTART_EN
          // A critical word in the last beat still needs the RESP slot.
          state_d = (word_idx == LAST_BEAT) ? RESP : IDLE;
`else
          state_d = RESP;
`endif
        end
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      beat_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    addr_d     = addr_q;
    beat_d     = beat_q;
    rsp_data_d = rsp_data_q;
    if ((state_q == IDLE) && cpu_req_valid) addr_d = cpu_req_addr;
    if ((state_q == CHECK) && lk_hit) rsp_data_d = lk_data;
    if (state_q == MISS_REQ) beat_d = '0;
    if (beat_fire) beat_d = beat_q + 1'b1;
    if (beat_crit) rsp_data_d = mem_rsp_data;
`ifdef ICACHE_EARLY_RESTART_EN
    rsp_valid_d = (state_d == RESP) || (beat_crit && !beat_last);
`else
    rsp_valid_d = (state_d == RESP);
`endif
  end

  // Output decode; fill port is combinational from the incoming beat
  always_comb begin
    cpu_req_ready = (state_q == IDLE);
    cpu_rsp_valid = rsp_valid_q;
    cpu_rsp_data  = rsp_data_q;
    lk_valid      = (state_q == LOOKUP);
    lk_addr       = lk_valid ? addr_q : '0;
    mem_req_valid = (state_q == MISS_REQ);
    mem_req_addr  = mem_req_valid ? line_base : '0;
    fill_we       = beat_fire;
    fill_addr     = beat_fire ? {addr_q[ADDR_W-1:OFF], beat_q, 2'b00} : '0;
    fill_data     = beat_fire ? mem_rsp_data : '0;
    fill_last     = beat_last;
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: cache/memory models plus
// response and fill scoreboards.
`default_nettype none

module tb_icache_refill_ctrl;

`ifdef ICACHE_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_req_ready;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_data;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic        lk_hit = 1'b0;
  logic [31:0] lk_data = '0;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        fill_last;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  icache_refill_ctrl #(.LINE_WORDS(8), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data), .fill_last(fill_last),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; logic l; } fill_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rsp_cnt = 0;
  int          exp_rsp = 0;
  int          rsp_cyc = 0;
  int          last_fill_cyc = 0;
  int          crit_cyc = 0;
  int          req_cyc = 0;
  int          mem_req_cycles = 0;
  logic [31:0] crit_addr = '0;
  logic [31:0] rsp_q[$];
  fill_t       fill_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Cache array model: lookups answered one cycle later, fills stored,
  // a line becomes valid only when its last beat is written.
  logic [31:0] cmem [int];
  bit          cvalid [int];
  logic        lk_v_s;
  logic [31:0] lk_a_s;

  always @(negedge clk) begin
    lk_v_s = lk_valid;
    lk_a_s = lk_addr;
    if (fill_we) begin
      cmem[int'(fill_addr >> 2)] = fill_data;
      if (fill_last) cvalid[int'(fill_addr >> 5)] = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (lk_v_s) begin
      lk_hit  = cvalid.exists(int'(lk_a_s >> 5)) && cvalid[int'(lk_a_s >> 5)];
      lk_data = cmem.exists(int'(lk_a_s >> 2)) ? cmem[int'(lk_a_s >> 2)] : 32'h0;
    end
  end

  // Response and fill scoreboards
  always @(negedge clk) begin
    if (mem_req_valid) mem_req_cycles++;
    if (cpu_rsp_valid) begin
      rsp_cyc = cyc;
      rsp_cnt++;
      if (rsp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
      else check_eq("rsp_data", cpu_rsp_data, rsp_q.pop_front());
    end
    if (fill_we) begin
      if (fill_q.size() == 0) begin
        check_eq("fill_unexpected", 1, 0);
      end else begin
        fill_t e;
        e = fill_q.pop_front();
        check_eq("fill_addr", fill_addr, e.a);
        check_eq("fill_data", fill_data, e.d);
        check_eq("fill_last", fill_last, e.l);
      end
      if (fill_last) last_fill_cyc = cyc;
      if (fill_addr == crit_addr) crit_cyc = cyc;
    end
  end

  task automatic do_req(input logic [31:0] a, output int acc);
    int t = 0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    acc = -1;
    do begin @(negedge clk); t++; end while (!cpu_req_ready && t < 50);
    if (!cpu_req_ready) check_eq("req_timeout", 0, 1);
    else acc = cyc;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic mem_serve(input logic [31:0] base, input logic [31:0] d0,
                           input int stall, input int gap, input int nbeats);
    int t = 0;
    @(negedge clk);
    while (!mem_req_valid && t < 50) begin @(negedge clk); t++; end
    if (!mem_req_valid) begin
      check_eq("mem_req_timeout", 0, 1);
      return;
    end
    req_cyc = cyc;
    check_eq("mem_req_addr", mem_req_addr, base);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_req_valid", mem_req_valid, 1);
      check_eq("stall_req_addr", mem_req_addr, base);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0 && gap > 0) begin repeat (gap) @(posedge clk); #1; end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d0 + 32'(b);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    int t = 0;
    #1;
    while (rsp_cnt < exp_rsp && t < 50) begin @(negedge clk); #1; t++; end
    if (rsp_cnt < exp_rsp) check_eq("rsp_timeout", rsp_cnt, exp_rsp);
  endtask

  task automatic run_miss(input logic [31:0] a, input logic [31:0] d0,
                          input int stall, input int gap, output int acc);
    logic [31:0] base;
    logic [31:0] widx;
    base = a & ~32'h1F;
    widx = (a >> 2) & 32'h7;
    for (int i = 0; i < 8; i++) fill_q.push_back('{base + 32'(4 * i), d0 + 32'(i), i == 7});
    rsp_q.push_back(d0 + widx);
    exp_rsp++;
    crit_addr = base + 4 * widx;
    do_req(a, acc);
    mem_serve(base, d0, stall, gap, 8);
    @(negedge clk);
    check_eq("ready_after_refill", cpu_req_ready, EARLY);
    wait_rsp();
    check_eq("miss_req_lat", req_cyc - acc, 3);
    check_eq("miss_rsp_lat", rsp_cyc - (EARLY ? crit_cyc : last_fill_cyc), 1);
    check_eq("fill_count", fill_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ready"}, cpu_req_ready, 1);
    check_eq({tag, "_ctl"}, {cpu_rsp_valid, lk_valid, fill_we, fill_last, mem_req_valid}, 0);
    check_eq({tag, "_rdata"}, cpu_rsp_data, 0);
    check_eq({tag, "_addr"}, lk_addr | fill_addr | mem_req_addr | fill_data, 0);
  endtask

  initial begin
    int acc, acc2, mreq;
    // Reset state
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Hit
    cmem[int'(32'h1008 >> 2)] = 32'hDEADBEEF;
    cvalid[int'(32'h1000 >> 5)] = 1'b1;
    rsp_q.push_back(32'hDEADBEEF);
    exp_rsp++;
    mreq = mem_req_cycles;
    do_req(32'h1008, acc);
    wait_rsp();
    check_eq("hit_lat", rsp_cyc - acc, 3);
    check_eq("hit_no_mem_req", mem_req_cycles - mreq, 0);
    cvalid[int'(32'h1000 >> 5)] = 1'b0;

    // Plain miss, critical word 5
    run_miss(32'h1014, 32'hA0, 0, 0, acc);

    // Request stall and inter-beat gaps
    run_miss(32'h4014, 32'hB0, 5, 2, acc);

    // Reset during refill after beat 3
    for (int i = 0; i < 4; i++) fill_q.push_back('{32'h5000 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0});
    crit_addr = 32'h5008;
    do_req(32'h5008, acc);
    mem_serve(32'h5000, 32'hC0, 0, 0, 4);
    reset = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0BAD0BAD;
    #1;
    check_quiet("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    check_eq("midrst_fills", fill_q.size(), 0);
    check_eq("midrst_no_rsp", rsp_cnt, exp_rsp);
    run_miss(32'h5008, 32'hC0, 0, 0, acc);

    // Back-to-back: hit then miss
    cmem[int'(32'h2000 >> 2)] = 32'h12345678;
    cvalid[int'(32'h2000 >> 5)] = 1'b1;
    rsp_q.push_back(32'h12345678);
    exp_rsp++;
    do_req(32'h2000, acc);
    run_miss(32'h3004, 32'hD0, 0, 1, acc2);
    check_eq("b2b_accept", acc2 - acc, 4);

    repeat (3) @(negedge clk);
    check_eq("rsp_drained", rsp_q.size(), 0);
    check_eq("rsp_total", rsp_cnt, exp_rsp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
